mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-port access request, bit i = port i.
REQ-006 we  input  2  per-port write select (1 = write, 0 = read), qualified by req.
REQ-007 addr0, addr1  input  ADDR_W each  per-port address.
REQ-008 wdata0, wdata1  input  DATA_W each  per-port write data.
REQ-009 gnt  output  2  one-hot grant, port currently being served.
REQ-010 ack  output  2  one-cycle completion pulse per port.
REQ-011 rvalid  output  2  one-cycle read-data-valid pulse per port.
REQ-012 rdata  output  DATA_W  read data, shared by both ports, meaningful only when an rvalid bit is high.
REQ-013 m_addr  output  ADDR_W  memory address.
REQ-014 m_wdata  output  DATA_W  memory write data.
REQ-015 m_wr_en, m_rd_en  output  1 each  memory write and read strobes.
REQ-016 m_rdata  input  DATA_W  memory read data, registered inside memory, updated on the edge that samples m_rd_en.

Function
REQ-017 FSM states IDLE, ISSUE and RESP shall be used; transitions IDLE->ISSUE when any req bit is high, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-018 In IDLE, on the edge leaving IDLE, the arbiter shall select one port, latch that port's we/addr/wdata, and set gnt one-hot.
REQ-019 Single requester: that port shall be granted; both requesting: port not equal to last_served shall be granted (round-robin).
REQ-020 last_served shall update to the granted port on the IDLE->ISSUE edge.
REQ-021 In ISSUE, m_addr/m_wdata shall carry latched values, and exactly one of m_wr_en (write) or m_rd_en (read) shall be high, driven from registers.
REQ-022 In RESP, ack[g] shall be high for exactly one cycle; rvalid[g] shall be high in the same cycle only for reads; rdata shall equal m_rdata.
REQ-023 gnt shall stay high through ISSUE and RESP and clear on the RESP->IDLE edge.
REQ-024 Latency: req sampled at edge N gives ack in cycle N+2 (counting cycle after edge N as N+1); peak throughput one access per 3 cycles.
REQ-025 Requester shall hold req/we/addr/wdata until ack; deasserting req before ack shall not cancel the transaction, and ack shall still pulse.
REQ-026 req held high after ack shall be treated as a new request in the following IDLE cycle.
REQ-027 m_wr_en and m_rd_en shall never be high in the same cycle, and both shall be low outside ISSUE.
REQ-028 Addresses shall pass unmodified; no range check is applied, since all 2^ADDR_W values are valid.

Reset
REQ-029 On rst: state=IDLE, gnt=0, ack=0, rvalid=0, m_wr_en=0, m_rd_en=0, m_addr=0, m_wdata=0, latched command=0, last_served=1 (port 0 wins first conflict).
REQ-030 rst asserted in ISSUE or RESP shall abort the transaction with no ack; a write strobe already sampled by memory is not undone.
REQ-031 The arbiter shall not drive memory rst; memory contents are reset separately.

Configuration
REQ-032 Macro MEM_ARB_FIXED_PRI_EN defined: port 0 shall always win conflicts, and last_served shall be ignored.
REQ-033 Macro MEM_ARB_FIXED_PRI_EN undefined: round-robin per REQ-019/REQ-020.

Verification
REQ-034 Port 0 write addr=0x05 wdata=0xA5, then port 0 read addr=0x05 -> write ack, then read rvalid[0]=1 with rdata=0xA5.
REQ-035 Both ports read simultaneously, held continuously, right after reset -> grants alternate 01,10,01,10; each ack 3 cycles apart (round-robin build).
REQ-036 Same as REQ-035 with MEM_ARB_FIXED_PRI_EN -> gnt stays 01 until port 0 drops req, then 10.
REQ-037 Port 1 write addr=0x7F wdata=0x3C with req dropped after 1 cycle -> ack[1] still pulses; later read of 0x7F returns 0x3C.
REQ-038 rst asserted during ISSUE of port 0 read -> no ack/rvalid; all outputs 0 the next cycle; next conflict granted to port 0.
REQ-039 Write then read with no idle cycles -> m_wr_en and m_rd_en are never high together; rvalid only on reads.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Each access takes three cycles:
// IDLE (choose a port) -> ISSUE (memory strobe) -> RESP (ack/rvalid).
// Conflicts are resolved round-robin by default.
// Define MEM_ARB_FIXED_PRI_EN to give port 0 fixed priority instead.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_wr_en_o,
  output logic              m_rd_en_o,
  input  logic [DATA_W-1:0] m_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                m_wr_en_q, m_wr_en_d;
  logic                m_rd_en_q, m_rd_en_d;
  logic                last_q, last_d;  // index of the port granted most recently
  logic                pick;            // port to grant if a request is taken now

  // Select port 1 only when it requests and port 0 does not outrank it.
`ifdef MEM_ARB_FIXED_PRI_EN
  assign pick = req_i[1] & ~req_i[0];
`else
  assign pick = req_i[1] & (~req_i[0] | ~last_q);
`endif

  // Next-state logic for the access sequence and its latched command.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = 2'b00;
    rvalid_d  = 2'b00;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wr_en_d = 1'b0;
    m_rd_en_d = 1'b0;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d   = StIssue;
          gnt_d     = pick ? 2'b10 : 2'b01;
          we_d      = we_i[pick];
          m_addr_d  = pick ? addr1_i : addr0_i;
          m_wdata_d = pick ? wdata1_i : wdata0_i;
          // Strobes are registered so they are glitch-free for the whole ISSUE cycle.
          m_wr_en_d = we_i[pick];
          m_rd_en_d = ~we_i[pick];
          last_d    = pick;
        end
      end
      StIssue: begin
        state_d  = StResp;
        ack_d    = gnt_q;
        rvalid_d = we_q ? 2'b00 : gnt_q;
      end
      StResp: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      ack_q     <= 2'b00;
      rvalid_q  <= 2'b00;
      we_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_en_q <= 1'b0;
      m_rd_en_q <= 1'b0;
      last_q    <= 1'b1;  // port 0 wins the first conflict
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      we_q      <= we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wr_en_q <= m_wr_en_d;
      m_rd_en_q <= m_rd_en_d;
      last_q    <= last_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign rvalid_o  = rvalid_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign m_wr_en_o = m_wr_en_q;
  assign m_rd_en_o = m_rd_en_q;
  // Memory data is only forwarded while a read response is valid.
  assign rdata_o   = (|rvalid_q) ? m_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered 128x8 memory model.
// Conflict expectations follow MEM_ARB_FIXED_PRI_EN when it is defined.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, ack, rvalid;
  logic [7:0] rdata, m_wdata, m_rdata;
  logic [6:0] m_addr;
  logic       m_wr_en, m_rd_en;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] mem [128];

  mem_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .we_i     (we),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .gnt_o    (gnt),
    .ack_o    (ack),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .m_addr_o (m_addr),
    .m_wdata_o(m_wdata),
    .m_wr_en_o(m_wr_en),
    .m_rd_en_o(m_rd_en),
    .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered memory: read data appears on the edge that samples the read strobe.
  always @(posedge clk) begin
    if (m_wr_en) mem[m_addr] <= m_wdata;
    if (m_rd_en) m_rdata <= mem[m_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rst_ack: got %b want 00", ack); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL rst_rvalid: got %b want 00", rvalid); end
    checks++; if ({m_wr_en, m_rd_en} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %b want 00", {m_wr_en, m_rd_en}); end
    checks++; if (m_addr !== 7'h00) begin failures++; $display("FAIL rst_addr: got %h want 00", m_addr); end
    checks++; if (m_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata: got %h want 00", m_wdata); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL idle_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_write_read;
    req = 2'b01; we = 2'b01; addr0 = 7'h05; wdata0 = 8'hA5;
    tick();  // ISSUE
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    checks++; if ({m_wr_en, m_rd_en} !== 2'b10) begin failures++; $display("FAIL wr_strobe: got %b want 10", {m_wr_en, m_rd_en}); end
    checks++; if (m_addr !== 7'h05) begin failures++; $display("FAIL wr_addr: got %h want 05", m_addr); end
    checks++; if (m_wdata !== 8'hA5) begin failures++; $display("FAIL wr_wdata: got %h want a5", m_wdata); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL wr_early_ack: got %b want 00", ack); end
    tick();  // RESP
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL wr_ack: got %b want 01", ack); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL wr_rvalid: got %b want 00", rvalid); end
    checks++; if ({m_wr_en, m_rd_en} !== 2'b00) begin failures++; $display("FAIL resp_strobe: got %b want 00", {m_wr_en, m_rd_en}); end
    we = 2'b00;
    tick();  // IDLE
    checks++; if ({gnt, ack} !== 4'b0000) begin failures++; $display("FAIL idle_clear: got %b want 0000", {gnt, ack}); end
    tick();  // ISSUE
    checks++; if ({m_wr_en, m_rd_en} !== 2'b01) begin failures++; $display("FAIL rd_strobe: got %b want 01", {m_wr_en, m_rd_en}); end
    tick();  // RESP
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rd_ack: got %b want 01", ack); end
    checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
    checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL rd_data: got %h want a5", rdata); end
    req = 2'b00;
    tick();  // IDLE
  endtask

  task automatic test_conflict;
    logic [1:0] exp;
    int last_ack;
    last_ack = 0;
    rst = 1'b1; req = 2'b11; we = 2'b00; addr0 = 7'h05; addr1 = 7'h05;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      exp = 2'b01;
`else
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tick();  // ISSUE
      checks++; if (gnt !== exp) begin failures++; $display("FAIL arb_gnt[%0d]: got %b want %b", i, gnt, exp); end
      tick();  // RESP
      checks++; if (ack !== exp) begin failures++; $display("FAIL arb_ack[%0d]: got %b want %b", i, ack, exp); end
      if (i > 0) begin
        checks++; if (cyc - last_ack !== 3) begin failures++; $display("FAIL arb_spacing[%0d]: got %0d want 3", i, cyc - last_ack); end
      end
      last_ack = cyc;
      tick();  // IDLE
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL arb_clear[%0d]: got %b want 00", i, gnt); end
    end
    req = 2'b10;
    tick();
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL arb_p1_alone: got %b want 10", gnt); end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_drop_req;
    req = 2'b10; we = 2'b10; addr1 = 7'h7F; wdata1 = 8'h3C;
    tick();  // ISSUE
    req = 2'b00;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL drop_gnt: got %b want 10", gnt); end
    checks++; if ({m_wr_en, m_addr, m_wdata} !== {1'b1, 7'h7F, 8'h3C}) begin failures++; $display("FAIL drop_cmd: got %b %h %h want 1 7f 3c", m_wr_en, m_addr, m_wdata); end
    tick();  // RESP
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL drop_ack: got %b want 10", ack); end
    tick();  // IDLE
    req = 2'b10; we = 2'b00;
    tick();
    tick();
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL drop_rvalid: got %b want 10", rvalid); end
    checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL drop_rdata: got %h want 3c", rdata); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_abort;
    req = 2'b01; we = 2'b00; addr0 = 7'h05;
    tick();  // ISSUE
    checks++; if (m_rd_en !== 1'b1) begin failures++; $display("FAIL abort_rd: got %b want 1", m_rd_en); end
    rst = 1'b1; req = 2'b00;
    tick();
    checks++; if ({gnt, ack, rvalid, m_wr_en, m_rd_en} !== 8'h00) begin failures++; $display("FAIL abort_ctl: got %b want 0", {gnt, ack, rvalid, m_wr_en, m_rd_en}); end
    checks++; if ({m_addr, m_wdata, rdata} !== 23'h0) begin failures++; $display("FAIL abort_data: got %h want 0", {m_addr, m_wdata, rdata}); end
    rst = 1'b0;
    tick();
    checks++; if ({ack, rvalid} !== 4'b0000) begin failures++; $display("FAIL abort_noack: got %b want 0000", {ack, rvalid}); end
    req = 2'b11;
    tick();
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_next_gnt: got %b want 01", gnt); end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    req = 2'b01; we = 2'b01; addr0 = 7'h10; wdata0 = 8'h5A;
    tick();  // ISSUE write
    checks++; if ({m_wr_en, m_rd_en} !== 2'b10) begin failures++; $display("FAIL b2b_wr: got %b want 10", {m_wr_en, m_rd_en}); end
    tick();  // RESP write
    checks++; if ({ack, rvalid} !== 4'b0100) begin failures++; $display("FAIL b2b_wr_resp: got %b want 0100", {ack, rvalid}); end
    we = 2'b00;
    tick();  // IDLE
    checks++; if ({m_wr_en, m_rd_en} !== 2'b00) begin failures++; $display("FAIL b2b_idle: got %b want 00", {m_wr_en, m_rd_en}); end
    tick();  // ISSUE read
    checks++; if ({m_wr_en, m_rd_en} !== 2'b01) begin failures++; $display("FAIL b2b_rd: got %b want 01", {m_wr_en, m_rd_en}); end
    tick();  // RESP read
    checks++; if ({ack, rvalid} !== 4'b0101) begin failures++; $display("FAIL b2b_rd_resp: got %b want 0101", {ack, rvalid}); end
    checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL b2b_rdata: got %h want 5a", rdata); end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_drop_req();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
